// File: rtl/sound_fx.sv
// sound_fx: arbitrates game event pulses and plays a short note sequence per effect as a square wave.
// Optional build macro SOUND_MUTE_EN adds a `mute` input that gates the registered `sound` output.
module sound_fx #(
    parameter int DUR_SCALE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] game_tick,
    input  logic       game_start_pulse,
    input  logic       jump_pulse,
    input  logic       game_over_pulse,
`ifdef SOUND_MUTE_EN
    input  logic       mute,
`endif
    output logic       sound,
    output logic       busy,
    output logic [1:0] effect
);

    typedef enum logic {S_IDLE = 1'b0, S_PLAY = 1'b1} state_t;

    localparam logic [1:0] EFF_NONE  = 2'b00;
    localparam logic [1:0] EFF_JUMP  = 2'b01;
    localparam logic [1:0] EFF_START = 2'b10;
    localparam logic [1:0] EFF_OVER  = 2'b11;

    state_t      r_state, w_state_n;
    logic [1:0]  r_effect, w_effect_n;
    logic [1:0]  r_idx, w_idx_n;
    logic [15:0] r_div, w_div_n;
    logic [6:0]  r_ticks, w_ticks_n;
    logic        r_sound, w_sound_n;

    logic [1:0]  w_req;
    logic        w_accept;
    logic [15:0] w_hp;
    logic [2:0]  w_dur;
    logic        w_last;
    logic [6:0]  w_dur_lim;
    logic        w_tick;
    logic        w_unused;

    assign w_tick   = game_tick[0];
    assign w_unused = game_tick[1];

    always_comb begin
        if (game_over_pulse)       w_req = EFF_OVER;
        else if (game_start_pulse) w_req = EFF_START;
        else if (jump_pulse)       w_req = EFF_JUMP;
        else                       w_req = EFF_NONE;
    end

    // Effect codes are ordered by priority, so a plain compare implements the arbitration.
    assign w_accept = (w_req != EFF_NONE) && ((r_state == S_IDLE) || (w_req >= r_effect));

    always_comb begin
        w_hp   = 16'd1;
        w_dur  = 3'd1;
        w_last = 1'b1;
        case ({r_effect, r_idx})
            4'b01_00: begin w_hp = 16'd14205; w_dur = 3'd1; w_last = 1'b0; end
            4'b01_01: begin w_hp = 16'd9480;  w_dur = 3'd1; end
            4'b10_00: begin w_hp = 16'd23889; w_dur = 3'd1; w_last = 1'b0; end
            4'b10_01: begin w_hp = 16'd18961; w_dur = 3'd1; w_last = 1'b0; end
            4'b10_10: begin w_hp = 16'd15944; w_dur = 3'd2; end
            4'b11_00: begin w_hp = 16'd31888; w_dur = 3'd2; w_last = 1'b0; end
            4'b11_01: begin w_hp = 16'd37921; w_dur = 3'd2; w_last = 1'b0; end
            4'b11_10: begin w_hp = 16'd47778; w_dur = 3'd4; end
            default: ;
        endcase
    end

    assign w_dur_lim = 7'(w_dur) * 7'(DUR_SCALE);

    always_comb begin
        w_state_n  = r_state;
        w_effect_n = r_effect;
        w_idx_n    = r_idx;
        w_div_n    = r_div;
        w_ticks_n  = r_ticks;
        w_sound_n  = r_sound;
        if (w_accept) begin
            w_state_n  = S_PLAY;
            w_effect_n = w_req;
            w_idx_n    = 2'd0;
            w_div_n    = 16'd0;
            w_ticks_n  = 7'd0;
            w_sound_n  = 1'b0;
        end else if (r_state == S_PLAY) begin
            if (r_div == w_hp - 16'd1) begin
                w_div_n   = 16'd0;
                w_sound_n = ~r_sound;
            end else begin
                w_div_n = r_div + 16'd1;
            end
            // A note end overrides the divider step taken on the same edge.
            if (w_tick) begin
                if (r_ticks + 7'd1 == w_dur_lim) begin
                    w_div_n   = 16'd0;
                    w_ticks_n = 7'd0;
                    w_sound_n = 1'b0;
                    if (w_last) begin
                        w_state_n  = S_IDLE;
                        w_effect_n = EFF_NONE;
                        w_idx_n    = 2'd0;
                    end else begin
                        w_idx_n = r_idx + 2'd1;
                    end
                end else begin
                    w_ticks_n = r_ticks + 7'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_effect <= EFF_NONE;
            r_idx    <= 2'd0;
            r_div    <= 16'd0;
            r_ticks  <= 7'd0;
            r_sound  <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_effect <= w_effect_n;
            r_idx    <= w_idx_n;
            r_div    <= w_div_n;
            r_ticks  <= w_ticks_n;
            r_sound  <= w_sound_n;
        end
    end

    assign busy   = (r_state == S_PLAY);
    assign effect = r_effect;

`ifdef SOUND_MUTE_EN
    // The waveform phase keeps running in r_sound; only the pin copy is gated.
    logic r_sound_out;
    always_ff @(posedge clk) begin
        if (rst) r_sound_out <= 1'b0;
        else     r_sound_out <= w_sound_n & ~mute;
    end
    assign sound = r_sound_out;
`else
    assign sound = r_sound;
`endif

endmodule

// File: doc/sound_fx.md
# sound_fx

Sound-effect sequencer on the receiving end of the player controller's event pulses. It consumes `game_start_pulse`, `jump_pulse` and `game_over_pulse`, arbitrates them by priority, and plays a short fixed melody for each as a 1-bit square wave for the audio pin. Note timing comes from the shared `game_tick[0]` frame tick, and pitch comes from clock-cycle dividers that assume a nominal 25 MHz `clk`.

## Interface
- `DUR_SCALE`, default 1: `game_tick[0]` pulses per note-duration unit. Legal range 1–15.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `game_tick`  in  2  frame ticks. Only bit 0 is used; it is a 1-cycle pulse.
- `game_start_pulse`  in  1  1-cycle request for the START effect.
- `jump_pulse`  in  1  1-cycle request for the JUMP effect.
- `game_over_pulse`  in  1  1-cycle request for the OVER effect.
- `sound`  out  1  square-wave audio output.
- `busy`  out  1  high while any effect is playing.
- `effect`  out  2  effect now playing: 00 none, 01 JUMP, 10 START, 11 OVER.
- `mute`  in  1  exists only with `SOUND_MUTE_EN`.

## Operation
- States: IDLE and PLAY.
  - IDLE: `sound`=0, `busy`=0, `effect`=00.
  - PLAY: `busy`=1.
- Note ROM: each entry holds a 16-bit half-period HP (clk cycles) and a duration D (in units).
  - JUMP: A5 HP=14205 D=1; E6 HP=9480 D=1.
  - START: C5 HP=23889 D=1; E5 HP=18961 D=1; G5 HP=15944 D=2.
  - OVER: G4 HP=31888 D=2; E4 HP=37921 D=2; C4 HP=47778 D=4.
- Priority is OVER > START > JUMP. Simultaneous requests select the highest priority.
- Accepting a request, from IDLE or PLAY, does all of the following:
  - load the effect;
  - set note index to 0;
  - clear the divider counter, the duration counter and `sound` to 0.
- A request is accepted in PLAY only if its priority is ≥ that of the effect playing; otherwise it is dropped.
  - Equal priority restarts the effect from note 0.
- Divider:
  - Counter runs 0..HP-1 every clk in PLAY.
  - At HP-1 it wraps to 0 and `sound` toggles.
  - Square-wave period is 2·HP clk cycles.
- Duration:
  - Each `game_tick[0]` in PLAY increments a 7-bit tick counter.
  - When the counter reaches D·DUR_SCALE, the note ends on that edge.
  - If another note follows: advance the index and clear the divider, tick counter and `sound`.
  - If it is the last note: go to IDLE.
- A request on the same cycle as a note-end tick wins. The new effect starts and that tick is not counted.
- A `game_tick[0]` on the acceptance cycle is not counted.

## Timing
- Reset: `sound`=0, `busy`=0, `effect`=00, state IDLE, all counters 0. Reset mid-effect silences on the next edge.
- Request to `busy`/`effect` valid: 1 cycle (registered, visible the cycle after the pulse).
- First `sound` rise: HP cycles after the acceptance edge.
- Note change: the new HP applies from the cycle after the ending tick, with `sound` low.
- Final note end: `busy`=0 and `sound`=0 the cycle after the last counted tick.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- `SOUND_MUTE_EN` defined:
  - The `mute` port exists.
  - While `mute`=1, `sound` is forced to 0 (registered, 1-cycle latency).
  - Sequencing, `busy` and `effect` are unaffected.
  - Releasing `mute` resumes the current waveform phase.
- Not defined: no `mute` port, and `sound` is never gated.

## Test plan
- Reset check: assert `rst` for 2 cycles mid-OVER. Next cycle `sound`=0, `busy`=0, `effect`=00. Then hold idle 1000 cycles with no pulses → `sound` stays 0.
- JUMP pitch and duration, DUR_SCALE=1:
  - Stimulus: `jump_pulse` at cycle 0, `game_tick[0]` every 50000 cycles.
  - `effect`=01 from cycle 1; first `sound` rise 14205 cycles after acceptance.
  - After tick 1, period 18960.
  - After tick 2, `busy`=0.
- Priority:
  - `jump_pulse` and `game_over_pulse` in the same cycle → `effect`=11.
  - A later `jump_pulse` during OVER is ignored: `effect` stays 11 and the note index is unchanged.
- Restart: `game_start_pulse`, then a second `game_start_pulse` during note E5 → back to C5 (half-period 23889) with the tick counter cleared.
- DUR_SCALE=3 with OVER → `busy` high for exactly 24 `game_tick[0]` pulses. Notes change after the 6th and 12th ticks.
- `SOUND_MUTE_EN` build: `mute`=1 during START → `sound`=0 throughout while `busy`=1. Drop `mute` → toggling resumes at the current C5/E5/G5 period.
